// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: one-start-per-pass instruction sequencer for the single-core NPU (Q/K load, kernel preload, execute, OFIFO drain).
// Define SFP_NORM_EN to add the SFP normalise phases (NORM_A/NORM_B) between OFIFO drain and FIN.
module core_seq_ctrl #(
  parameter int COL    = 8,
  parameter int ADDR_W = 4,
  parameter int DRAIN  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] q_len_m1,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ofifo_valid,
  output logic [19:0]       inst,
  output logic              busy,
  output logic              done
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] COL_M1 = CW'(COL - 1);
  localparam logic [CW-1:0] KL_END = CW'(COL + DRAIN - 1);
`ifdef SFP_NORM_EN
  typedef enum logic [3:0] {IDLE, LD_Q, LD_K, KLOAD, EXEC, OFIFO, FIN, NORM_A, NORM_B} state_t;
`else
  typedef enum logic [2:0] {IDLE, LD_Q, LD_K, KLOAD, EXEC, OFIFO, FIN} state_t;
`endif
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt, qlen_ext;
  logic [ADDR_W-1:0] qlen, a;
  logic ld_q, ld_k, kl, ex, of;
  assign qlen_ext = {1'b0, qlen};
  assign a        = cnt[ADDR_W-1:0];
  assign ld_q     = state == LD_Q;
  assign ld_k     = state == LD_K;
  assign kl       = state == KLOAD && cnt <= COL_M1;
  assign ex       = state == EXEC;
  assign of       = state == OFIFO && ofifo_valid;
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      IDLE:   if (start) nxt = LD_Q;
      LD_Q:   if (in_valid) begin
                if (cnt == qlen_ext) nxt = LD_K;
                else cnt_nxt = cnt + 1'b1;
              end
      LD_K:   if (in_valid) begin
                if (cnt == COL_M1) nxt = KLOAD;
                else cnt_nxt = cnt + 1'b1;
              end
      // KLOAD covers the preload cycles followed by the settle (drain) cycles
      KLOAD:  if (cnt == KL_END) nxt = EXEC;
              else cnt_nxt = cnt + 1'b1;
      EXEC:   if (cnt == qlen_ext) nxt = OFIFO;
              else cnt_nxt = cnt + 1'b1;
      OFIFO:  if (ofifo_valid) begin
`ifdef SFP_NORM_EN
                if (cnt == qlen_ext) nxt = NORM_A;
`else
                if (cnt == qlen_ext) nxt = FIN;
`endif
                else cnt_nxt = cnt + 1'b1;
              end
`ifdef SFP_NORM_EN
      NORM_A: if (cnt == qlen_ext + 1'b1) nxt = NORM_B;
              else cnt_nxt = cnt + 1'b1;
      NORM_B: if (cnt == qlen_ext + 1'b1) nxt = FIN;
              else cnt_nxt = cnt + 1'b1;
`endif
      FIN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
    if (nxt != state) cnt_nxt = '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      qlen     <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= cnt_nxt;
      if (state == IDLE && nxt == LD_Q) qlen <= q_len_m1;
      in_ready <= nxt == LD_Q || nxt == LD_K;
      busy     <= nxt != IDLE;
      done     <= nxt == FIN;
    end
  end
`ifdef SFP_NORM_EN
  logic na, nb_rd, nb_wr;
  assign na    = state == NORM_A && cnt <= qlen_ext;
  assign nb_rd = state == NORM_B && cnt <= qlen_ext;
  assign nb_wr = state == NORM_B && cnt != '0;
`endif
  always_comb begin
    inst        = '0;
    inst[15:12] = (ld_q || ld_k || kl || ex) ? a : '0;
    inst[7]     = ex;
    inst[6]     = kl;
    inst[5]     = ex;
    inst[4]     = ld_q && in_valid;
    inst[3]     = kl;
    inst[2]     = ld_k && in_valid;
    inst[16]    = of;
`ifdef SFP_NORM_EN
    // write-back trails the read by one cycle (SRAM read latency), so it addresses cnt-1
    inst[19]    = nb_wr;
    inst[18]    = nb_rd;
    inst[17]    = na;
    inst[1]     = na || nb_rd;
    inst[0]     = of || nb_wr;
    inst[11:8]  = nb_wr ? a - 1'b1 : (of || na || nb_rd) ? a : '0;
`else
    inst[0]     = of;
    inst[11:8]  = of ? a : '0;
`endif
  end
endmodule
